// File: rtl/id_ex_pipe_reg_if.sv
// ----------------------------------------------------------------------------
// id_ex_if : signal bundle between the decode stage and the ID/EX pipeline
// register of the RV32I core.
//   *_d          decode-stage control/data presented to the register
//   i_flush_e    taken branch/jump resolved in EX
//   i_hold_e     multi-cycle EX unit freezes the EX register
//   i_cnt_clr    synchronous clear of the bubble counter
//   o_*_e        registered EX-stage copies
//   o_stall_fd   freeze PC and IF/ID (combinational)
//   o_bubble_cnt saturating count of inserted bubbles
// Modports: master = decode/control side, slave = the pipeline register.
// ----------------------------------------------------------------------------
interface id_ex_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             i_valid_d;
  logic [1:0]       i_result_src_d;
  logic             i_branch_d;
  logic             i_jmp_d;
  logic             i_mem_write_d;
  logic             i_reg_write_d;
  logic [2:0]       i_alu_ctl_d;
  logic             i_alu_src_d;
  logic [XLEN-1:0]  i_rd1_d;
  logic [XLEN-1:0]  i_rd2_d;
  logic [XLEN-1:0]  i_pc_d;
  logic [XLEN-1:0]  i_pc_plus4_d;
  logic [XLEN-1:0]  i_imm_ext_d;
  logic [4:0]       i_rs1_d;
  logic [4:0]       i_rs2_d;
  logic [4:0]       i_rd_d;
  logic             i_flush_e;
  logic             i_hold_e;
  logic             i_cnt_clr;

  logic             o_valid_e;
  logic [1:0]       o_result_src_e;
  logic             o_branch_e;
  logic             o_jmp_e;
  logic             o_mem_write_e;
  logic             o_reg_write_e;
  logic [2:0]       o_alu_ctl_e;
  logic             o_alu_src_e;
  logic [XLEN-1:0]  o_rd1_e;
  logic [XLEN-1:0]  o_rd2_e;
  logic [XLEN-1:0]  o_pc_e;
  logic [XLEN-1:0]  o_pc_plus4_e;
  logic [XLEN-1:0]  o_imm_ext_e;
  logic [4:0]       o_rs1_e;
  logic [4:0]       o_rs2_e;
  logic [4:0]       o_rd_e;
  logic             o_stall_fd;
  logic [CNT_W-1:0] o_bubble_cnt;

  modport master (
    output i_valid_d, i_result_src_d, i_branch_d, i_jmp_d, i_mem_write_d,
           i_reg_write_d, i_alu_ctl_d, i_alu_src_d, i_rd1_d, i_rd2_d, i_pc_d,
           i_pc_plus4_d, i_imm_ext_d, i_rs1_d, i_rs2_d, i_rd_d,
           i_flush_e, i_hold_e, i_cnt_clr,
    input  o_valid_e, o_result_src_e, o_branch_e, o_jmp_e, o_mem_write_e,
           o_reg_write_e, o_alu_ctl_e, o_alu_src_e, o_rd1_e, o_rd2_e, o_pc_e,
           o_pc_plus4_e, o_imm_ext_e, o_rs1_e, o_rs2_e, o_rd_e,
           o_stall_fd, o_bubble_cnt
  );

  modport slave (
    input  i_valid_d, i_result_src_d, i_branch_d, i_jmp_d, i_mem_write_d,
           i_reg_write_d, i_alu_ctl_d, i_alu_src_d, i_rd1_d, i_rd2_d, i_pc_d,
           i_pc_plus4_d, i_imm_ext_d, i_rs1_d, i_rs2_d, i_rd_d,
           i_flush_e, i_hold_e, i_cnt_clr,
    output o_valid_e, o_result_src_e, o_branch_e, o_jmp_e, o_mem_write_e,
           o_reg_write_e, o_alu_ctl_e, o_alu_src_e, o_rd1_e, o_rd2_e, o_pc_e,
           o_pc_plus4_e, o_imm_ext_e, o_rs1_e, o_rs2_e, o_rd_e,
           o_stall_fd, o_bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ----------------------------------------------------------------------------
// id_ex_pipe_reg : ID/EX pipeline register of the 5-stage RV32I core.
// Latches decode control, register-file data, PC and immediate into EX,
// detects load-use hazards (stalls F/D and inserts a bubble), honours EX
// flush and EX hold, and counts inserted bubbles with a saturating counter.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      id_ex_if.slave : all *_d inputs, flush/hold/clear controls,
//            registered *_e outputs, o_stall_fd and o_bubble_cnt
// ----------------------------------------------------------------------------
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic [1:0]      result_src;
    logic            branch;
    logic            jmp;
    logic            mem_write;
    logic            reg_write;
    logic [2:0]      alu_ctl;
    logic            alu_src;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] imm_ext;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } ex_fields_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ex_fields_t       e_r;
  ex_fields_t       e_nxt_s;
  ex_fields_t       d_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             lu_s;
  logic             stall_s;
  logic             bubble_s;

  // Gather the decode-stage fields into one record.
  always_comb begin
    d_s            = '0;
    d_s.valid      = bus.i_valid_d;
    d_s.result_src = bus.i_result_src_d;
    d_s.branch     = bus.i_branch_d;
    d_s.jmp        = bus.i_jmp_d;
    d_s.mem_write  = bus.i_mem_write_d;
    d_s.reg_write  = bus.i_reg_write_d;
    d_s.alu_ctl    = bus.i_alu_ctl_d;
    d_s.alu_src    = bus.i_alu_src_d;
    d_s.rd1        = bus.i_rd1_d;
    d_s.rd2        = bus.i_rd2_d;
    d_s.pc         = bus.i_pc_d;
    d_s.pc_plus4   = bus.i_pc_plus4_d;
    d_s.imm_ext    = bus.i_imm_ext_d;
    d_s.rs1        = bus.i_rs1_d;
    d_s.rs2        = bus.i_rs2_d;
    d_s.rd         = bus.i_rd_d;
  end

  // Load-use detection, stall request and bubble decision.
  // x0 is never a real destination, so rd=0 cannot create a hazard.
  always_comb begin
    lu_s     = e_r.valid & (e_r.result_src == 2'b01) & (e_r.rd != 5'd0) &
               bus.i_valid_d &
               ((bus.i_rs1_d == e_r.rd) | (bus.i_rs2_d == e_r.rd));
    // A flush squashes the ID instruction anyway, so there is nothing to stall.
    stall_s  = ~bus.i_flush_e & (lu_s | bus.i_hold_e);
    // Hold outranks the load-use bubble; flush outranks both.
    bubble_s = bus.i_flush_e | (~bus.i_hold_e & lu_s);
  end

  // Next EX register contents: flush > hold > load-use bubble > load.
  always_comb begin
    e_nxt_s = e_r;
    if (bus.i_flush_e) begin
      e_nxt_s = '0;
    end else if (bus.i_hold_e) begin
      e_nxt_s = e_r;
    end else if (lu_s) begin
      e_nxt_s = '0;
    end else begin
      e_nxt_s = d_s;
    end
  end

  // Next bubble count: clear wins, otherwise saturating increment.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (bus.i_cnt_clr) begin
      cnt_nxt_s = '0;
    end else if (bubble_s && (cnt_r != CNT_MAX)) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // EX-stage register and bubble counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      e_r   <= '0;
      cnt_r <= '0;
    end else begin
      e_r   <= e_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  assign bus.o_valid_e      = e_r.valid;
  assign bus.o_result_src_e = e_r.result_src;
  assign bus.o_branch_e     = e_r.branch;
  assign bus.o_jmp_e        = e_r.jmp;
  assign bus.o_mem_write_e  = e_r.mem_write;
  assign bus.o_reg_write_e  = e_r.reg_write;
  assign bus.o_alu_ctl_e    = e_r.alu_ctl;
  assign bus.o_alu_src_e    = e_r.alu_src;
  assign bus.o_rd1_e        = e_r.rd1;
  assign bus.o_rd2_e        = e_r.rd2;
  assign bus.o_pc_e         = e_r.pc;
  assign bus.o_pc_plus4_e   = e_r.pc_plus4;
  assign bus.o_imm_ext_e    = e_r.imm_ext;
  assign bus.o_rs1_e        = e_r.rs1;
  assign bus.o_rs2_e        = e_r.rs2;
  assign bus.o_rd_e         = e_r.rd;
  assign bus.o_stall_fd     = stall_s;
  assign bus.o_bubble_cnt   = cnt_r;

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage RV32I core. Sits directly downstream of the decode control path.
- Latches decode control fields plus register-file, PC and immediate data into the Execute stage.
- Owns load-use hazard detection: raises the F/D stall and inserts bubbles.
- Handles EX-stage branch/jump flush, an external EX hold, and a saturating bubble counter.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, bubble counter width.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid_d  in  1  ID stage holds a real instruction.
- i_result_src_d  in  2  00 ALU, 01 memory (load), 10 PC+4.
- i_branch_d, i_jmp_d, i_mem_write_d, i_reg_write_d, i_alu_src_d  in  1 each  decode control.
- i_alu_ctl_d  in  3  ALU operation.
- i_rd1_d, i_rd2_d, i_pc_d, i_pc_plus4_d, i_imm_ext_d  in  XLEN each  ID data.
- i_rs1_d, i_rs2_d, i_rd_d  in  5 each  register indices.
- i_flush_e  in  1  taken branch/jump resolved in EX; squash the ID instruction.
- i_hold_e  in  1  freeze the EX register (multi-cycle EX unit).
- i_cnt_clr  in  1  synchronous clear of the bubble counter.
- o_valid_e, o_result_src_e, o_branch_e, o_jmp_e, o_mem_write_e, o_reg_write_e, o_alu_ctl_e, o_alu_src_e, o_rd1_e, o_rd2_e, o_pc_e, o_pc_plus4_e, o_imm_ext_e, o_rs1_e, o_rs2_e, o_rd_e  out  widths as the matching inputs  registered EX-stage copies.
- o_stall_fd  out  1  combinational; freeze PC and IF/ID.
- o_bubble_cnt  out  CNT_W  bubbles inserted since reset/clear.

Behaviour:
- Reset (async, i_rst_n=0): every registered output and o_bubble_cnt go to 0 immediately. o_stall_fd reads 0 because it is derived from o_valid_e=0 and i_hold_e. Reset mid-stall discards the pending bubble; the first edge after release performs a normal load.
- Load-use hazard, combinational: lu = o_valid_e & (o_result_src_e==01) & (o_rd_e!=0) & i_valid_d & ((i_rs1_d==o_rd_e) | (i_rs2_d==o_rd_e)).
- o_stall_fd = ~i_flush_e & (lu | i_hold_e).
- Per-edge action, in priority order:
  1. i_flush_e=1: insert bubble.
  2. i_hold_e=1: all E registers keep their values.
  3. lu=1: insert bubble.
  4. Otherwise: load all *_d inputs into *_e; o_valid_e <= i_valid_d.
- Bubble: o_valid_e, all control outputs, o_rd_e, o_rs1_e, o_rs2_e and all XLEN data outputs become 0. A bubble therefore never writes memory or the register file.
- An invalid ID input (i_valid_d=0) loads as is. Downstream stages qualify on o_valid_e. Such a load is not counted as a bubble.
- Load latency is 1 cycle, ID to EX.
- Load-use sequence: the stall lasts exactly one cycle. After the bubble, o_valid_e=0, so lu drops and the stalled instruction loads on the following edge.
- Flush and lu in the same cycle: flush wins, o_stall_fd=0, one bubble, counted once.
- Flush and hold in the same cycle: flush wins.
- Bubble counter, evaluated per edge:
  - i_cnt_clr=1 sets it to 0; clear wins over a simultaneous increment.
  - Otherwise it increments by 1 on each flush- or lu-inserted bubble.
  - It saturates at 2^CNT_W-1 and never wraps.
- Register index 0 never triggers a hazard.

Test Plan:
- Reset: drive all inputs to 1s, assert i_rst_n=0 asynchronously between edges. All outputs read 0 before the next edge and o_stall_fd=0.
- Normal flow: i_valid_d=1, i_pc_d=0x100, i_rd_d=5, i_reg_write_d=1, i_alu_ctl_d=010 -> one edge later o_pc_e=0x100, o_rd_e=5, o_reg_write_e=1, o_valid_e=1, o_stall_fd=0.
- Load-use: EX holds a load (result_src 01, rd=7); ID has rs2=7.
  - Expect o_stall_fd=1 for one cycle and the next-edge E register all zero.
  - Expect o_bubble_cnt=1.
  - The edge after that loads the ID instruction with o_stall_fd=0.
  - Repeat with rd=0: no stall.
- Flush priority: same hazard setup plus i_flush_e=1.
  - Expect o_stall_fd=0, one bubble, o_bubble_cnt increments by exactly 1.
  - Separately, i_flush_e=1 with i_hold_e=1 -> bubble, not hold.
- Hold: i_hold_e=1 for 3 cycles while ID inputs change. E outputs stay constant, o_stall_fd=1, counter unchanged. Release -> the current ID values load.
- Counter: with CNT_W=4, force 16 bubbles -> count stays at 0xF. Then i_cnt_clr=1 together with a flush-bubble -> count is 0.
